mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
Iterative multiply/divide unit with HI/LO registers. It sits directly downstream of the register file in the single-cycle CPU and consumes RS/RT read data for MULT/MULTU/DIV/DIVU. Results are exposed for MFHI/MFLO writeback, and HI/LO can be written directly for MTHI/MTLO. The CPU holds its PC while busy_o or start_i is asserted.

Parameters:
DATA_W, 32, operand/HI/LO width. Iteration count equals DATA_W, one bit per cycle.
CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > DATA_W.

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  asynchronous, active-low reset
start_i  input  1  launch operation; sampled only in IDLE
op_i  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with start_i
src1_i  input  DATA_W  RS data: multiplicand or dividend
src2_i  input  DATA_W  RT data: multiplier or divisor
hi_we_i  input  1  MTHI write enable
lo_we_i  input  1  MTLO write enable
wdata_i  input  DATA_W  MTHI/MTLO data
busy_o  output  1  registered; high in CALC and FIX
done_o  output  1  registered; one-cycle pulse when HI/LO receive a result
div_by_zero_o  output  1  registered; pulses with done_o on a divide with src2=0
hi_o  output  DATA_W  HI register
lo_o  output  DATA_W  LO register

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE, counter=0, all working registers=0, hi_o=lo_o=0, busy_o=done_o=div_by_zero_o=0. Reset during CALC/FIX aborts the operation: no done_o, and HI/LO are zero.
- FSM: IDLE -> CALC -> FIX -> IDLE.
- IDLE, start_i=1 at edge E:
  - latch op_i, abs(src1_i)/abs(src2_i) (signed ops) or raw operands, and result-sign flags.
  - counter=0; busy_o=1 after E.
- CALC, edges E+1..E+DATA_W:
  - Multiply: shift-add, one multiplier bit per edge, into a 2*DATA_W accumulator.
  - Divide: restoring shift-subtract, one quotient bit per edge.
  - counter increments each edge; leave CALC when counter reaches DATA_W-1 at that edge.
- FIX, edge E+DATA_W+1:
  - Apply sign correction and load HI/LO.
  - done_o=1, state=IDLE, busy_o=0.
  - done_o and div_by_zero_o clear at the next edge.
  - With DATA_W=32, start at edge 0 gives results at edge 33.
- Result rules:
  - MULT/MULTU: {HI,LO} = full 2*DATA_W product; MULT is two's-complement.
  - DIVU: LO=quotient, HI=remainder.
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero (either divide): LO=all ones, HI=src1 as latched (unsigned/raw bits), div_by_zero_o=1. Full latency still applies.
  - DIV of most-negative by -1: LO=0x80000000, HI=0, no flag.
- MTHI/MTLO:
  - In IDLE, without start_i: hi_we_i/lo_we_i load wdata_i at the edge; both may assert together.
  - start_i and a write in the same IDLE cycle: start wins, write dropped.
  - Writes while busy_o=1: ignored.
- start_i while busy_o=1: ignored. The operation in flight is unaffected.
- start_i in the cycle after done_o: accepted normally, giving back-to-back operation.
- hi_o/lo_o hold their previous values throughout CALC; they change only at FIX or on an accepted write.

Test Plan:
- MULTU src1=0xFFFFFFFF, src2=0xFFFFFFFF, start at edge 0 -> busy_o high edges 1-32, done_o after edge 33, HI=0xFFFFFFFE, LO=0x00000001.
- MULT src1=0xFFFFFFFD (-3), src2=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; then DIV src1=0xFFFFFFF9 (-7), src2=2 started the cycle after done_o -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU src1=0x64, src2=0 -> LO=0xFFFFFFFF, HI=0x00000064, div_by_zero_o=1 with done_o. Also DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0, flag 0.
- DIVU 100/7 started; at edge 5 assert start_i with new operands plus hi_we_i -> both ignored; result LO=14, HI=2.
- MTHI wdata=0x12345678 and MTLO 0x9ABCDEF0 in IDLE -> hi_o/lo_o update next edge. Same-cycle start_i+lo_we_i -> write dropped, operation runs.
- rst_i low asynchronously at edge 10 of a MULT -> outputs zero immediately, no done_o. After release, a new MULTU 6*7 gives LO=42, HI=0.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers: shift-add multiply and
// restoring divide, one bit per cycle, followed by a sign-fix cycle.
module mul_div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic              hi_we_i,
    input  logic              lo_we_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              div_by_zero_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [1:0]            r_op;
    logic [DATA_W-1:0]     r_m;
    logic [DATA_W-1:0]     r_raw1;
    logic [2*DATA_W-1:0]   r_acc;
    logic                  r_neg_res;
    logic                  r_neg_rem;
    logic [DATA_W-1:0]     r_hi;
    logic [DATA_W-1:0]     r_lo;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_dbz;

    logic                  w_launch;
    logic                  w_step;
    logic                  w_finish;
    logic                  w_wr_hi;
    logic                  w_wr_lo;

    // Start handshake: start_i acts as valid and "not busy" as ready; a start
    // is taken only in IDLE, and it wins over a same-cycle MTHI/MTLO write.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_next = S_CALC;
            S_CALC:  if (r_cnt == CNT_LAST) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_launch = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        w_wr_hi  = 1'b0;
        w_wr_lo  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_launch = start_i;
                w_wr_hi  = !start_i && hi_we_i;
                w_wr_lo  = !start_i && lo_we_i;
            end
            S_CALC:  w_step   = 1'b1;
            S_FIX:   w_finish = 1'b1;
            default: ;
        endcase
    end

    // Operand preparation: signed ops run on magnitudes, sign restored at FIX.
    logic              w_neg1;
    logic              w_neg2;
    logic [DATA_W-1:0] w_abs1;
    logic [DATA_W-1:0] w_abs2;

    assign w_neg1 = op_i[0] & src1_i[DATA_W-1];
    assign w_neg2 = op_i[0] & src2_i[DATA_W-1];
    assign w_abs1 = w_neg1 ? -src1_i : src1_i;
    assign w_abs2 = w_neg2 ? -src2_i : src2_i;

    // Multiply: r_acc = {partial product, remaining multiplier bits}.
    logic [DATA_W:0]     w_mul_sum;
    logic [2*DATA_W-1:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[DATA_W-1:1]};

    // Divide: r_acc = {partial remainder, dividend bits shifting into quotient}.
    logic [DATA_W:0]     w_rem_sh;
    logic [DATA_W:0]     w_diff;
    logic [2*DATA_W-1:0] w_div_next;

    assign w_rem_sh   = {r_acc[2*DATA_W-1:DATA_W], r_acc[DATA_W-1]};
    assign w_diff     = w_rem_sh - {1'b0, r_m};
    assign w_div_next = w_diff[DATA_W]
                      ? {w_rem_sh[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0}
                      : {w_diff[DATA_W-1:0],   r_acc[DATA_W-2:0], 1'b1};

    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quo;
    logic [DATA_W-1:0]   w_rem;
    logic                w_dbz;
    logic [DATA_W-1:0]   w_res_hi;
    logic [DATA_W-1:0]   w_res_lo;

    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quo  = r_neg_res ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
    assign w_rem  = r_neg_rem ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];
    assign w_dbz  = r_op[1] && (r_m == '0);

    always_comb begin
        w_res_hi = w_prod[2*DATA_W-1:DATA_W];
        w_res_lo = w_prod[DATA_W-1:0];
        if (r_op[1]) begin
            if (w_dbz) begin
                w_res_hi = r_raw1;
                w_res_lo = '1;
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quo;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt     <= '0;
            r_op      <= '0;
            r_m       <= '0;
            r_raw1    <= '0;
            r_acc     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
            if (w_launch) begin
                r_cnt     <= '0;
                r_op      <= op_i;
                r_raw1    <= src1_i;
                r_neg_res <= w_neg1 ^ w_neg2;
                r_neg_rem <= w_neg1;
                if (op_i[1]) begin
                    r_m   <= w_abs2;
                    r_acc <= {{DATA_W{1'b0}}, w_abs1};
                end else begin
                    r_m   <= w_abs1;
                    r_acc <= {{DATA_W{1'b0}}, w_abs2};
                end
            end
            if (w_step) begin
                r_cnt <= r_cnt + CNT_ONE;
                r_acc <= r_op[1] ? w_div_next : w_mul_next;
            end
            if (w_finish) begin
                r_hi   <= w_res_hi;
                r_lo   <= w_res_lo;
                r_done <= 1'b1;
                r_dbz  <= w_dbz;
            end
            if (w_wr_hi) r_hi <= wdata_i;
            if (w_wr_lo) r_lo <= wdata_i;
        end
    end

    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign div_by_zero_o = r_dbz;
    assign hi_o          = r_hi;
    assign lo_o          = r_lo;
    assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed scenarios with literal
// expectations plus randomized traffic against a latency-count result model.
module tb_mul_div_unit;

  localparam int DATA_W = 32;
  localparam int LAT    = DATA_W + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic              start_i = 1'b0;
  logic [1:0]        op_i = '0;
  logic [DATA_W-1:0] src1_i = '0;
  logic [DATA_W-1:0] src2_i = '0;
  logic              hi_we_i = 1'b0;
  logic              lo_we_i = 1'b0;
  logic [DATA_W-1:0] wdata_i = '0;
  logic              busy_o;
  logic              done_o;
  logic              div_by_zero_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic [1:0]        dbg_state;

  mul_div_unit #(.DATA_W(DATA_W), .CNT_W(6)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_i), .op_i(op_i),
    .src1_i(src1_i), .src2_i(src2_i), .hi_we_i(hi_we_i), .lo_we_i(lo_we_i),
    .wdata_i(wdata_i), .busy_o(busy_o), .done_o(done_o),
    .div_by_zero_o(div_by_zero_o), .hi_o(hi_o), .lo_o(lo_o),
    .dbg_state_o(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference arithmetic
  task automatic compute(input logic [1:0] op, input logic [DATA_W-1:0] a, b,
                         output logic [DATA_W-1:0] hi, lo, output logic dbz);
    longint unsigned up;
    longint sa, sb, p, q, r;
    dbz = 1'b0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: begin
        up = {32'b0, a} * {32'b0, b};
        hi = up[63:32]; lo = up[31:0];
      end
      2'b01: begin
        p = sa * sb;
        hi = p[63:32]; lo = p[31:0];
      end
      default: begin
        if (b == '0) begin
          hi = a; lo = '1; dbz = 1'b1;
        end else if (op == 2'b10) begin
          hi = a % b; lo = a / b;
        end else begin
          q = sa / sb; r = sa % sb;
          hi = r[31:0]; lo = q[31:0];
        end
      end
    endcase
  endtask

  // behavioural model: an accepted start yields its result LAT edges later
  logic              m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
  logic [DATA_W-1:0] m_hi = '0, m_lo = '0;
  logic [DATA_W-1:0] p_hi, p_lo;
  logic              p_dbz;
  int                m_left = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0;
      m_hi = '0; m_lo = '0; m_left = 0;
    end else begin
      m_done = 1'b0;
      m_dbz  = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_dbz = p_dbz;
          m_hi = p_hi; m_lo = p_lo;
        end
      end else if (start_i) begin
        compute(op_i, src1_i, src2_i, p_hi, p_lo, p_dbz);
        m_busy = 1'b1;
        m_left = LAT;
      end else begin
        if (hi_we_i) m_hi = wdata_i;
        if (lo_we_i) m_lo = wdata_i;
      end
    end
  end

  // scoreboard: every falling edge the outputs must match the model
  always @(negedge clk) begin
    if ($time > 2) begin
      n_tests++;
      if ({busy_o, done_o, div_by_zero_o, hi_o, lo_o} !== {m_busy, m_done, m_dbz, m_hi, m_lo}) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t got busy=%b done=%b dbz=%b hi=%h lo=%h expected busy=%b done=%b dbz=%b hi=%h lo=%h",
                 $time, busy_o, done_o, div_by_zero_o, hi_o, lo_o, m_busy, m_done, m_dbz, m_hi, m_lo);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks: entered and left at #1 after a rising edge
  task automatic go(input logic [1:0] op, input logic [DATA_W-1:0] a, b);
    start_i = 1'b1; op_i = op; src1_i = a; src2_i = b;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    for (n = 0; n < 100; n++) begin
      if (done_o) break;
      @(posedge clk); #1;
    end
    if (n == 100) begin
      n_fail++;
      $display("FAIL %s_timeout: got no done_o, required done_o within 100 cycles", name);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_opnd();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'h8000_0000;
      2: return '1;
      3: return 32'($urandom_range(0, 20));
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    logic [DATA_W-1:0] eh, el;
    logic ed;

    // pin the reference arithmetic with hand-computed values
    compute(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, eh, el, ed);
    check("model_multu", {eh, el}, 64'hFFFF_FFFE_0000_0001);
    compute(2'b11, 32'hFFFF_FFF9, 32'h2, eh, el, ed);
    check("model_div", {eh, el}, 64'hFFFF_FFFF_FFFF_FFFD);
    compute(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, eh, el, ed);
    check("model_div_ovf", {eh, el, 31'b0, ed}, {64'h0000_0000_8000_0000, 32'h0});

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_state", {hi_o, lo_o, busy_o, done_o, div_by_zero_o}, '0);

    // MULTU full-scale with cycle-exact latency
    go(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("busy_after_start", {busy_o, done_o}, 2'b10);
    repeat (32) begin @(posedge clk); #1; end
    check("busy_edge32", {busy_o, done_o, hi_o, lo_o}, {2'b10, 64'h0});
    @(posedge clk); #1;
    check("done_edge33", {busy_o, done_o, hi_o, lo_o}, {2'b01, 64'hFFFF_FFFE_0000_0001});

    // MULT then back-to-back DIV
    go(2'b01, 32'hFFFF_FFFD, 32'h7);
    wait_done("mult");
    check("mult_neg3x7", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFEB);
    go(2'b11, 32'hFFFF_FFF9, 32'h2);
    wait_done("div_b2b");
    check("div_neg7by2", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);

    // divide by zero and most-negative / -1
    go(2'b10, 32'h64, 32'h0);
    wait_done("divu0");
    check("divu_by_zero", {hi_o, lo_o, div_by_zero_o}, {64'h0000_0064_FFFF_FFFF, 1'b1});
    go(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("divovf");
    check("div_ovf", {hi_o, lo_o, div_by_zero_o}, {64'h0000_0000_8000_0000, 1'b0});

    // start and write while busy are ignored
    go(2'b10, 32'd100, 32'd7);
    repeat (4) begin @(posedge clk); #1; end
    start_i = 1'b1; op_i = 2'b00; src1_i = 32'd9; src2_i = 32'd9;
    hi_we_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start_i = 1'b0; hi_we_i = 1'b0;
    wait_done("divu_busy");
    check("divu_100by7", {hi_o, lo_o}, {32'd2, 32'd14});
    @(posedge clk); #1;

    // MTHI / MTLO
    hi_we_i = 1'b1; wdata_i = 32'h1234_5678;
    @(posedge clk); #1;
    hi_we_i = 1'b0;
    check("mthi", hi_o, 64'h1234_5678);
    lo_we_i = 1'b1; wdata_i = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    lo_we_i = 1'b0;
    check("mtlo", {hi_o, lo_o}, 64'h1234_5678_9ABC_DEF0);
    lo_we_i = 1'b1; wdata_i = 32'h5555_AAAA;
    go(2'b00, 32'd3, 32'd5);
    lo_we_i = 1'b0;
    check("start_wins_write", {busy_o, lo_o}, {1'b1, 32'h9ABC_DEF0});
    wait_done("multu35");
    check("multu_3x5", {hi_o, lo_o}, 64'd15);

    // asynchronous reset mid-operation
    go(2'b01, 32'hFFFF_FF00, 32'h0000_1234);
    repeat (9) begin @(posedge clk); #1; end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_reset", {busy_o, done_o, hi_o, lo_o}, '0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      check("no_done_after_abort", done_o, 64'h0);
    end
    go(2'b00, 32'd6, 32'd7);
    wait_done("multu67");
    check("multu_6x7", {hi_o, lo_o}, 64'd42);

    // randomized traffic; the scoreboard checks every cycle
    repeat (4000) begin
      start_i = ($urandom_range(0, 2) == 0);
      op_i    = 2'($urandom_range(0, 3));
      src1_i  = rand_opnd();
      src2_i  = rand_opnd();
      hi_we_i = ($urandom_range(0, 3) == 0);
      lo_we_i = ($urandom_range(0, 3) == 0);
      wdata_i = $urandom();
      @(posedge clk); #1;
    end
    start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
    repeat (LAT + 4) begin @(posedge clk); #1; end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
